// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and stop (8E1).
module uart_rx #(
  parameter int OS_DIV = 25
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       PARITY_ERR,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t     state;
  logic       rx_m;
  logic       rx_s;
  logic [7:0] div_cnt;
  logic       tick;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       bit_smp;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  assign tick = (div_cnt == 8'(OS_DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       div_cnt <= 8'd0;
    else if (tick) div_cnt <= 8'd0;
    else           div_cnt <= div_cnt + 8'd1;
  end

  // Mid-bit sample point: last oversample tick of a bit period.
  assign bit_smp = tick && (os_cnt == 4'd15);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_ok;

  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction

  assign par_ok = even_parity_ok(shift, par_bit);

  always_ff @(posedge CLK) begin
    if (state == S_DATA && bit_smp)   shift   <= {rx_s, shift[7:1]};
    if (state == S_PARITY && bit_smp) par_bit <= rx_s;
  end
`else
  assign PARITY_ERR = 1'b0;

  always_ff @(posedge CLK) begin
    if (state == S_DATA && bit_smp) shift <= {rx_s, shift[7:1]};
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      os_cnt     <= 4'd0;
      bit_cnt    <= 3'd0;
      DATA       <= 8'h00;
      VALID      <= 1'b0;
      FRAME_ERR  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
`endif
      BUSY       <= 1'b0;
    end else begin
      VALID      <= 1'b0;
      FRAME_ERR  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (tick && !rx_s) begin
            state  <= S_START;
            os_cnt <= 4'd0;
            BUSY   <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (os_cnt == 4'd7) begin
              os_cnt  <= 4'd0;
              bit_cnt <= 3'd0;
              if (!rx_s) begin
                state <= S_DATA;
              end else begin
                state <= S_IDLE;
                BUSY  <= 1'b0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                os_cnt <= 4'd0;
`ifdef UART_RX_PARITY_EN
                state  <= S_PARITY;
`else
                state  <= S_STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              os_cnt <= 4'd0;
              state  <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              os_cnt <= 4'd0;
              if (!rx_s) begin
                FRAME_ERR <= 1'b1;
                state     <= S_WAIT_HIGH;
              end else begin
                state <= S_IDLE;
                BUSY  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (par_ok) begin
                  DATA  <= shift;
                  VALID <= 1'b1;
                end else begin
                  PARITY_ERR <= 1'b1;
                end
`else
                DATA  <= shift;
                VALID <= 1'b1;
`endif
              end
            end
          end
        end
        // A stuck-low line parks here so it cannot be decoded as endless 0x00 frames.
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state  <= S_IDLE;
            os_cnt <= 4'd0;
            BUSY   <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          os_cnt <= 4'd0;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; frame-level reference model with event queues.
module tb_uart_rx;

  localparam int OS_DIV  = 25;
  localparam int BIT_CLK = 16 * OS_DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx #(.OS_DIV(OS_DIV)) dut (
    .CLK(clk),
    .RST(rst),
    .RX(rx),
    .DATA(data),
    .VALID(valid),
    .FRAME_ERR(frame_err),
    .PARITY_ERR(parity_err),
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event word: {valid, frame_err, parity_err, busy, data}
  logic [11:0] evq[$];
  logic [11:0] expq[$];
  logic [7:0]  exp_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (valid || frame_err || parity_err))
      evq.push_back({valid, frame_err, parity_err, busy, data});
  end

  // Reference: what one transmitted frame must produce, from the framing rules alone.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic par_bad);
    if (!stop) begin
      expq.push_back({3'b010, 1'b1, exp_data});
    end else if (PAR_EN && par_bad) begin
      expq.push_back({3'b001, 1'b0, exp_data});
    end else begin
      exp_data = b;
      expq.push_back({3'b100, 1'b0, b});
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop,
                            input logic par_bad, input bit modeled);
    if (modeled) model_frame(b, stop, par_bad);
    rx = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bclk) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = (^b) ^ par_bad;
      repeat (bclk) @(negedge clk);
    end
    rx = stop;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (evq.size() < expq.size() && n < 20 * BIT_CLK) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_count"}, evq.size(), expq.size());
    while (evq.size() > 0 && expq.size() > 0)
      check({tag, "_event"}, evq.pop_front(), expq.pop_front());
    evq.delete();
    expq.delete();
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    int         rbclk;
    logic       rstop;
    logic       rpb;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs", {data, valid, frame_err, parity_err, busy}, 12'h000);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    send_frame(8'hA5, BIT_CLK, 1'b1, 1'b0, 1'b1);
    drain("a5");
    check("a5_data", data, 8'hA5);
    check("a5_busy", busy, 1'b0);

    // Short low glitch must be rejected
    rx = 1'b0;
    repeat (150) @(negedge clk);
    rx = 1'b1;
    repeat (600) @(negedge clk);
    check("glitch_busy", busy, 1'b0);
    drain("glitch");
    check("glitch_data", data, exp_data);

    // Bad stop bit followed by a stuck-low line
    send_frame(8'h3C, BIT_CLK, 1'b0, 1'b0, 1'b1);
    repeat (2000) @(negedge clk);
    check("ferr_busy_low", busy, 1'b1);
    rx = 1'b1;
    repeat (3 * OS_DIV) @(negedge clk);
    check("ferr_busy_release", busy, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    drain("ferr");
    check("ferr_data", data, exp_data);

    // Back-to-back frames from a 3% fast transmitter
    send_frame(8'h00, 388, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 388, 1'b1, 1'b0, 1'b1);
    drain("b2b");
    check("b2b_data", data, 8'hFF);

    // Async reset in the middle of bit 4
    fork
      send_frame(8'h55, BIT_CLK, 1'b1, 1'b0, 1'b0);
      begin
        repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_immediate", {data, valid, frame_err, parity_err, busy}, 12'h000);
        repeat (3) @(negedge clk);
        check("rst_held", {data, valid, frame_err, parity_err, busy}, 12'h000);
        rst = 1'b0;
      end
    join
    repeat (8 * BIT_CLK) @(negedge clk);
    evq.delete();
    expq.delete();
    send_frame(8'h81, BIT_CLK, 1'b1, 1'b0, 1'b1);
    drain("rst_recover");
    check("rst_recover_data", data, 8'h81);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, BIT_CLK, 1'b1, 1'b1, 1'b1);
    drain("par_bad");
    check("par_bad_data", data, 8'h81);
    send_frame(8'h07, BIT_CLK, 1'b1, 1'b0, 1'b1);
    drain("par_good");
    check("par_good_data", data, 8'h07);
`endif

    for (int k = 0; k < 5; k++) begin
      rb    = 8'($urandom);
      rbclk = $urandom_range(412, 388);
      rstop = ($urandom_range(0, 4) != 0);
      rpb   = ($urandom_range(0, 3) == 0);
      send_frame(rb, rbclk, rstop, rpb, 1'b1);
      if (!rstop) begin
        rx = 1'b1;
        repeat (rbclk) @(negedge clk);
      end
      repeat ($urandom_range(0, rbclk)) @(negedge clk);
    end
    drain("random");
    check("random_data", data, exp_data);
    check("random_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
